// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: multi-cycle RV32I control FSM over a shared req/ready memory port.
// Define RISCV_MC_PERF_EN to add the cycle_count/instret performance counters.
module riscv_multicycle_ctrl #(
    parameter int ALU_CTRL_W = 4,
    parameter int MAX_WAIT   = 16
`ifdef RISCV_MC_PERF_EN
    ,
    parameter int PERF_W     = 32
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  N,
    input  logic                  Z,
    input  logic                  C,
    input  logic                  V,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_wren,
    output logic                  addr_sel,
    output logic                  ir_wren,
    output logic                  pc_wren,
    output logic                  regfile_wren,
    output logic [1:0]            alu_asel,
    output logic [1:0]            alu_bsel,
    output logic [1:0]            result_sel,
    output logic [2:0]            ximm_sel,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  fault,
    output logic [3:0]            state
`ifdef RISCV_MC_PERF_EN
    ,
    output logic [PERF_W-1:0]     cycle_count,
    output logic [PERF_W-1:0]     instret
`endif
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXECR  = 4'd6,  S_EXECI = 4'd7,
        S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR  = 4'd11,
        S_UPPER  = 4'd12, S_FAULT  = 4'd15
    } state_t;
    localparam int WW = MAX_WAIT > 1 ? $clog2(MAX_WAIT + 1) : 1;
    state_t cur, nxt;
    logic [WW-1:0] wait_cnt;
    logic taken, bad_br, is_jalr, is_jump;
    logic [3:0] op_r, op_i;
    // ALU op is {funct3, sub/arith bit}, so ADD=0 and SUB=1
    assign op_r = {funct3, funct7b5 & (funct3 == 3'b000 || funct3 == 3'b101)};
    assign op_i = {funct3, funct7b5 & (funct3 == 3'b101)};
    assign taken = (funct3[2] ? (funct3[1] ? !C : N ^ V) : Z) ^ funct3[0];
    assign bad_br = funct3[2:1] == 2'b01;
    assign is_jalr = opcode == 7'b1100111;
    assign is_jump = is_jalr || opcode == 7'b1101111;
    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            cur <= nxt;
            wait_cnt <= (mem_req && !mem_ready && nxt == cur) ? wait_cnt + 1'b1 : '0;
        end
    end
    always_comb begin
        nxt = cur;
        mem_req = 1'b0;
        mem_wren = 1'b0;
        addr_sel = 1'b0;
        ir_wren = 1'b0;
        pc_wren = 1'b0;
        regfile_wren = 1'b0;
        alu_asel = 2'd0;
        alu_bsel = 2'd0;
        result_sel = 2'd0;
        ximm_sel = 3'd0;
        alu_control = '0;
        fault = 1'b0;
        state = reset ? 4'd0 : cur;
        if (!reset) begin
            case (cur)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alu_bsel = 2'd2;
                    result_sel = 2'd2;
                    ir_wren = mem_ready;
                    pc_wren = mem_ready;
                    nxt = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_asel = 2'd1;
                    alu_bsel = 2'd1;
                    ximm_sel = 3'd2;
                    nxt = (opcode == 7'b0000011 || opcode == 7'b0100011) ? S_MEMADR :
                          opcode == 7'b0110011 ? S_EXECR :
                          opcode == 7'b0010011 ? S_EXECI :
                          opcode == 7'b1100011 ? S_BRANCH :
                          opcode == 7'b1101111 ? S_JAL :
                          opcode == 7'b1100111 ? S_JALR :
                          (opcode == 7'b0110111 || opcode == 7'b0010111) ? S_UPPER : S_FAULT;
                end
                S_MEMADR: begin
                    alu_asel = 2'd2;
                    alu_bsel = 2'd1;
                    ximm_sel = opcode[5] ? 3'd1 : 3'd0;
                    nxt = opcode[5] ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    addr_sel = 1'b1;
                    nxt = mem_ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    result_sel = 2'd1;
                    regfile_wren = 1'b1;
                    nxt = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req = 1'b1;
                    mem_wren = 1'b1;
                    addr_sel = 1'b1;
                    nxt = mem_ready ? S_FETCH : S_MEMWR;
                end
                S_EXECR: begin
                    alu_asel = 2'd2;
                    alu_control = ALU_CTRL_W'(op_r);
                    nxt = S_ALUWB;
                end
                S_EXECI: begin
                    alu_asel = 2'd2;
                    alu_bsel = 2'd1;
                    alu_control = ALU_CTRL_W'(op_i);
                    nxt = S_ALUWB;
                end
                S_ALUWB: begin
                    // after JAL/JALR this second sub-cycle loads PC with the jump target
                    regfile_wren = !is_jump;
                    pc_wren = is_jump;
                    result_sel = is_jump ? 2'd2 : 2'd0;
                    alu_asel = is_jump ? (is_jalr ? 2'd2 : 2'd1) : 2'd0;
                    alu_bsel = is_jump ? 2'd1 : 2'd0;
                    ximm_sel = (is_jump && !is_jalr) ? 3'd3 : 3'd0;
                    nxt = S_FETCH;
                end
                S_BRANCH: begin
                    alu_asel = 2'd2;
                    alu_control = ALU_CTRL_W'(1);
                    pc_wren = taken && !bad_br;
                    nxt = bad_br ? S_FAULT : S_FETCH;
                end
                S_JAL, S_JALR: begin
                    regfile_wren = 1'b1;
                    result_sel = 2'd2;
                    alu_asel = 2'd1;
                    alu_bsel = 2'd2;
                    nxt = S_ALUWB;
                end
                S_UPPER: begin
                    alu_asel = opcode[5] ? 2'd2 : 2'd1;
                    alu_bsel = 2'd1;
                    ximm_sel = 3'd4;
                    nxt = S_ALUWB;
                end
                S_FAULT: fault = 1'b1;
                default: nxt = S_FAULT;
            endcase
            if (MAX_WAIT != 0 && mem_req && !mem_ready && wait_cnt == WW'(MAX_WAIT - 1)) nxt = S_FAULT;
        end
    end
`ifdef RISCV_MC_PERF_EN
    logic [PERF_W-1:0] cyc_q, ret_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
            ret_q <= ret_q + PERF_W'(cur != S_FETCH && nxt == S_FETCH);
        end
    end
    assign cycle_count = reset ? '0 : cyc_q;
    assign instret = reset ? '0 : ret_q;
`endif
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb_riscv_multicycle_ctrl: directed stimulus pushes per-cycle expected controls; a negedge monitor pops and compares.
module tb_riscv_multicycle_ctrl;
    logic clk = 1'b0, reset = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic funct7b5 = 1'b0, N = 1'b0, Z = 1'b0, C = 1'b0, V = 1'b0, mem_ready = 1'b0;
    logic mem_req, mem_wren, addr_sel, ir_wren, pc_wren, regfile_wren, fault;
    logic [1:0] alu_asel, alu_bsel, result_sel;
    logic [2:0] ximm_sel;
    logic [3:0] alu_control, state;
`ifdef RISCV_MC_PERF_EN
    logic [3:0] cycle_count, instret;
`endif

    riscv_multicycle_ctrl #(
        .ALU_CTRL_W(4),
        .MAX_WAIT(16)
`ifdef RISCV_MC_PERF_EN
        , .PERF_W(4)
`endif
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .N(N), .Z(Z), .C(C), .V(V), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_wren(mem_wren), .addr_sel(addr_sel), .ir_wren(ir_wren),
        .pc_wren(pc_wren), .regfile_wren(regfile_wren), .alu_asel(alu_asel), .alu_bsel(alu_bsel),
        .result_sel(result_sel), .ximm_sel(ximm_sel), .alu_control(alu_control),
        .fault(fault), .state(state)
`ifdef RISCV_MC_PERF_EN
        , .cycle_count(cycle_count), .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [5:0] ctl;
        logic [1:0] as, bs, rs;
        logic [2:0] xs;
        logic [3:0] alu;
        logic       flt;
    } exp_t;

    exp_t exp_q[$];
    string tag_q[$];
    int compared = 0, mismatched = 0;
    exp_t e_mon, a_mon;
    string t_mon;

    // ctl = {mem_req, mem_wren, addr_sel, ir_wren, pc_wren, regfile_wren}
    function automatic exp_t mk(input logic [3:0] st, input logic [5:0] ctl, input logic [1:0] as, bs, rs,
                                input logic [2:0] xs, input logic [3:0] alu, input logic flt);
        return exp_t'({st, ctl, as, bs, rs, xs, alu, flt});
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e_mon = exp_q.pop_front();
            t_mon = tag_q.pop_front();
            a_mon = exp_t'({state, mem_req, mem_wren, addr_sel, ir_wren, pc_wren, regfile_wren,
                            alu_asel, alu_bsel, result_sel, ximm_sel, alu_control, fault});
            compared++;
            if (a_mon !== e_mon) begin
                mismatched++;
                $display("FAIL %s: got %h (state %0d ctl %b) expected %h (state %0d ctl %b)",
                         t_mon, a_mon, a_mon.st, a_mon.ctl, e_mon, e_mon.st, e_mon.ctl);
            end
        end
    end

    task automatic cyc(input logic rdy, input logic rst, input exp_t e, input string tag);
        mem_ready = rdy;
        reset = rst;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode = op;
        funct3 = f3;
        funct7b5 = f7;
    endtask

    exp_t E_RST, E_FW, E_FR, E_DEC, E_WB, E_MR, E_MWB, E_MW, E_FLT, E_JAL, E_JALR, E_JWB, E_JRWB;

    task automatic add_instr();
        ir(7'b0110011, 3'b000, 1'b0);
        cyc(1, 0, E_FR, "add fetch");
        cyc(1, 0, E_DEC, "add decode");
        cyc(1, 0, mk(6, 0, 2, 0, 0, 0, 0, 0), "add execr");
        cyc(1, 0, E_WB, "add aluwb");
    endtask

    task automatic branch(input logic [2:0] f3, input logic pcw, input string tag);
        ir(7'b1100011, f3, 1'b0);
        cyc(1, 0, E_FR, "br fetch");
        cyc(1, 0, E_DEC, "br decode");
        cyc(1, 0, mk(9, {4'b0, pcw, 1'b0}, 2, 0, 0, 0, 1, 0), tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d expectations pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        E_RST  = mk(0, 6'b000000, 0, 0, 0, 0, 0, 0);
        E_FW   = mk(0, 6'b100000, 0, 2, 2, 0, 0, 0);
        E_FR   = mk(0, 6'b100110, 0, 2, 2, 0, 0, 0);
        E_DEC  = mk(1, 6'b000000, 1, 1, 0, 2, 0, 0);
        E_WB   = mk(8, 6'b000001, 0, 0, 0, 0, 0, 0);
        E_MR   = mk(3, 6'b101000, 0, 0, 0, 0, 0, 0);
        E_MWB  = mk(4, 6'b000001, 0, 0, 1, 0, 0, 0);
        E_MW   = mk(5, 6'b111000, 0, 0, 0, 0, 0, 0);
        E_FLT  = mk(15, 6'b000000, 0, 0, 0, 0, 0, 1);
        E_JAL  = mk(10, 6'b000001, 1, 2, 2, 0, 0, 0);
        E_JALR = mk(11, 6'b000001, 1, 2, 2, 0, 0, 0);
        E_JWB  = mk(8, 6'b000010, 1, 1, 2, 3, 0, 0);
        E_JRWB = mk(8, 6'b000010, 2, 1, 2, 0, 0, 0);
        @(posedge clk);
        #1;
        cyc(1, 1, E_RST, "reset a");
        cyc(1, 1, E_RST, "reset b");
        add_instr();
        ir(7'b0110011, 3'b000, 1'b1);
        cyc(1, 0, E_FR, "sub fetch");
        cyc(1, 0, E_DEC, "sub decode");
        cyc(1, 0, mk(6, 0, 2, 0, 0, 0, 1, 0), "sub execr");
        cyc(1, 0, E_WB, "sub aluwb");
        ir(7'b0010011, 3'b101, 1'b1);
        cyc(1, 0, E_FR, "srai fetch");
        cyc(1, 0, E_DEC, "srai decode");
        cyc(1, 0, mk(7, 0, 2, 1, 0, 0, 4'd11, 0), "srai execi");
        cyc(1, 0, E_WB, "srai aluwb");
        ir(7'b0010011, 3'b000, 1'b1);
        cyc(1, 0, E_FR, "addi fetch");
        cyc(1, 0, E_DEC, "addi decode");
        cyc(1, 0, mk(7, 0, 2, 1, 0, 0, 0, 0), "addi f7 ignored");
        cyc(1, 0, E_WB, "addi aluwb");
        ir(7'b0000011, 3'b010, 1'b0);
        cyc(1, 0, E_FR, "lw fetch");
        cyc(1, 0, E_DEC, "lw decode");
        cyc(1, 0, mk(2, 0, 2, 1, 0, 0, 0, 0), "lw memadr");
        for (int i = 0; i < 3; i++) cyc(0, 0, E_MR, "lw memrd wait");
        cyc(1, 0, E_MR, "lw memrd ready");
        cyc(1, 0, E_MWB, "lw memwb");
        ir(7'b0100011, 3'b010, 1'b0);
        cyc(1, 0, E_FR, "sw fetch");
        cyc(1, 0, E_DEC, "sw decode");
        cyc(1, 0, mk(2, 0, 2, 1, 0, 1, 0, 0), "sw memadr");
        cyc(1, 0, E_MW, "sw memwr");
        Z = 1'b1;
        branch(3'b000, 1'b1, "beq Z=1 taken");
        branch(3'b001, 1'b0, "bne Z=1 not taken");
        Z = 1'b0; N = 1'b1; V = 1'b0; C = 1'b0;
        branch(3'b100, 1'b1, "blt N^V taken");
        branch(3'b111, 1'b0, "bgeu C=0 not taken");
        branch(3'b110, 1'b1, "bltu C=0 taken");
        N = 1'b0;
        ir(7'b1101111, 3'b000, 1'b0);
        cyc(1, 0, E_FR, "jal fetch");
        cyc(1, 0, E_DEC, "jal decode");
        cyc(1, 0, E_JAL, "jal link");
        cyc(1, 0, E_JWB, "jal target");
        ir(7'b1100111, 3'b000, 1'b0);
        cyc(1, 0, E_FR, "jalr fetch");
        cyc(1, 0, E_DEC, "jalr decode");
        cyc(1, 0, E_JALR, "jalr link");
        cyc(1, 0, E_JRWB, "jalr target");
        ir(7'b0110111, 3'b000, 1'b0);
        cyc(1, 0, E_FR, "lui fetch");
        cyc(1, 0, E_DEC, "lui decode");
        cyc(1, 0, mk(12, 0, 2, 1, 0, 4, 0, 0), "lui upper");
        cyc(1, 0, E_WB, "lui aluwb");
        ir(7'b0010111, 3'b000, 1'b0);
        cyc(1, 0, E_FR, "auipc fetch");
        cyc(1, 0, E_DEC, "auipc decode");
        cyc(1, 0, mk(12, 0, 1, 1, 0, 4, 0, 0), "auipc upper");
        cyc(1, 0, E_WB, "auipc aluwb");
        ir(7'b0100011, 3'b010, 1'b0);
        cyc(1, 0, E_FR, "sw2 fetch");
        cyc(1, 0, E_DEC, "sw2 decode");
        cyc(1, 0, mk(2, 0, 2, 1, 0, 1, 0, 0), "sw2 memadr");
        cyc(0, 0, E_MW, "sw2 memwr wait");
        cyc(1, 1, E_RST, "reset during memwr");
        cyc(0, 0, E_FW, "fetch after reset");
        for (int i = 0; i < 14; i++) cyc(0, 0, E_FW, "fetch wait 15");
        cyc(1, 0, E_FR, "fetch ready after 15 waits");
        ir(7'b0110011, 3'b000, 1'b0);
        cyc(1, 0, E_DEC, "decode after waits");
        cyc(1, 0, mk(6, 0, 2, 0, 0, 0, 0, 0), "execr after waits");
        cyc(1, 0, E_WB, "aluwb after waits");
        for (int i = 0; i < 16; i++) cyc(0, 0, E_FW, "fetch wait 16");
        cyc(0, 0, E_FLT, "timeout fault");
        cyc(1, 0, E_FLT, "timeout fault sticky");
        cyc(1, 1, E_RST, "reset clears timeout");
        ir(7'b1100011, 3'b010, 1'b0);
        cyc(1, 0, E_FR, "bad br fetch");
        cyc(1, 0, E_DEC, "bad br decode");
        cyc(1, 0, mk(9, 0, 2, 0, 0, 0, 1, 0), "bad br branch");
        cyc(1, 0, E_FLT, "bad br fault");
        cyc(1, 1, E_RST, "reset clears bad br");
        ir(7'b0000000, 3'b000, 1'b0);
        cyc(1, 0, E_FR, "bad op fetch");
        cyc(1, 0, E_DEC, "bad op decode");
        cyc(1, 0, E_FLT, "bad op fault");
        cyc(1, 0, E_FLT, "bad op fault sticky");
        cyc(1, 1, E_RST, "reset clears bad op");
        cyc(0, 0, E_FW, "fetch after fault reset");
`ifdef RISCV_MC_PERF_EN
        cyc(1, 1, E_RST, "perf reset");
        for (int i = 0; i < 16; i++) add_instr();
        compared++;
        if (instret !== 4'd0 || cycle_count !== 4'd0) begin
            mismatched++;
            $display("FAIL perf16: instret %0d cycle_count %0d expected 0 0", instret, cycle_count);
        end
        add_instr();
        compared++;
        if (instret !== 4'd1 || cycle_count !== 4'd4) begin
            mismatched++;
            $display("FAIL perf17: instret %0d cycle_count %0d expected 1 4", instret, cycle_count);
        end
`endif
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations never compared, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
